// File: rtl/aes_inv_round_ctrl_if.sv
// Control bundle between the AES inverse-cipher sequencer and the decrypt top / datapath.
// The sequencer uses the master modport; the top level and state register use the slave view.
interface aes_inv_round_ctrl_if;
    logic       start;
    logic       msg_load;
    logic [2:0] op;
    logic [1:0] column;
    logic [3:0] round;
    logic       state_load;
    logic       mix_all;
    logic       busy;
    logic       done;

    modport master (
        input  start,
        output msg_load, op, column, round, state_load, mix_all, busy, done
    );

    modport slave (
        output start,
        input  msg_load, op, column, round, state_load, mix_all, busy, done
    );
endinterface

// File: rtl/aes_inv_round_ctrl.sv
// Moore sequencer stepping a shared AES-128 inverse-round datapath through the full inverse cipher.
// Define INV_MIX_PARALLEL_EN to collapse InvMixColumns into one all-column cycle (drives mix_all).
module aes_inv_round_ctrl #(
    parameter int NUM_ROUNDS       = 10,
    parameter int SUB_BYTES_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    aes_inv_round_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, LOAD, ARK0, ISR, ISB, ARK, IMC, F_ISR, F_ISB, F_ARK, DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ARK = 3'd1,
        OP_ISR = 3'd2,
        OP_ISB = 3'd3,
        OP_IMC = 3'd4
    } op_t;

    localparam logic [3:0] ROUND_INIT = 4'(NUM_ROUNDS);
    localparam logic [1:0] SUB_LAST   = 2'(SUB_BYTES_CYCLES - 1);

    state_t     state, state_next;
    logic [3:0] round_cnt, round_next;
    logic [1:0] sub_cnt, sub_next;
    logic [3:0] round_dec;
    logic       round_last;

    // Saturating decrement; the final round always runs with index 0.
    assign round_dec  = (round_cnt == 4'd0) ? 4'd0 : round_cnt - 4'd1;
    assign round_last = (round_cnt <= 4'd1);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            round_cnt <= '0;
            sub_cnt   <= '0;
        end else begin
            state     <= state_next;
            round_cnt <= round_next;
            sub_cnt   <= sub_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no branch can infer a latch.
    always_comb begin
        state_next = state;
        round_next = round_cnt;
        sub_next   = sub_cnt;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                    round_next = ROUND_INIT;
                end
            end
            LOAD: state_next = ARK0;
            ARK0: begin
                round_next = round_dec;
                state_next = round_last ? F_ISR : ISR;
            end
            ISR: begin
                state_next = ISB;
                sub_next   = '0;
            end
            ISB: begin
                if (sub_cnt == SUB_LAST) begin
                    state_next = ARK;
                    sub_next   = '0;
                end else begin
                    sub_next = sub_cnt + 2'd1;
                end
            end
            ARK: begin
                state_next = IMC;
                sub_next   = '0;
            end
            IMC: begin
`ifdef INV_MIX_PARALLEL_EN
                round_next = round_dec;
                state_next = round_last ? F_ISR : ISR;
`else
                if (sub_cnt == 2'd3) begin
                    sub_next   = '0;
                    round_next = round_dec;
                    state_next = round_last ? F_ISR : ISR;
                end else begin
                    sub_next = sub_cnt + 2'd1;
                end
`endif
            end
            F_ISR: begin
                state_next = F_ISB;
                sub_next   = '0;
            end
            F_ISB: begin
                if (sub_cnt == SUB_LAST) begin
                    state_next = F_ARK;
                    sub_next   = '0;
                end else begin
                    sub_next = sub_cnt + 2'd1;
                end
            end
            F_ARK: state_next = DONE;
            DONE: begin
                if (!bus.start) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.msg_load   = 1'b0;
        bus.op         = OP_NOP;
        bus.column     = 2'd0;
        bus.round      = (state == IDLE) ? 4'd0 : round_cnt;
        bus.state_load = 1'b0;
        bus.mix_all    = 1'b0;
        bus.busy       = (state != IDLE) && (state != DONE);
        bus.done       = (state == DONE);
        unique case (state)
            LOAD: bus.msg_load = 1'b1;
            ARK0, ARK, F_ARK: begin
                bus.op         = OP_ARK;
                bus.state_load = 1'b1;
            end
            ISR, F_ISR: begin
                bus.op         = OP_ISR;
                bus.state_load = 1'b1;
            end
            ISB, F_ISB: begin
                bus.op         = OP_ISB;
                bus.state_load = (sub_cnt == SUB_LAST);
            end
            IMC: begin
                bus.op         = OP_IMC;
                bus.state_load = 1'b1;
`ifdef INV_MIX_PARALLEL_EN
                bus.mix_all    = 1'b1;
`else
                bus.column     = sub_cnt;
`endif
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Self-checking bench: two sequencers (SUB_BYTES_CYCLES 1 and 3) compared cycle by cycle
// against an op-trace model built from the inverse-cipher round schedule.
module tb_aes_inv_round_ctrl;
    localparam int NR = 10;
`ifdef INV_MIX_PARALLEL_EN
    localparam int IMC_CYCLES = 1;
`else
    localparam int IMC_CYCLES = 4;
`endif

    typedef struct packed {
        logic       msg_load;
        logic [2:0] op;
        logic [1:0] column;
        logic [3:0] round;
        logic       state_load;
        logic       mix_all;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];

    aes_inv_round_ctrl_if bus0();
    aes_inv_round_ctrl_if bus3();

    aes_inv_round_ctrl #(.NUM_ROUNDS(NR), .SUB_BYTES_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    aes_inv_round_ctrl #(.NUM_ROUNDS(NR), .SUB_BYTES_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t mk(input int op, input int col, input int rnd, input bit sl, input bit mix);
        obs_t e;
        e            = '0;
        e.op         = 3'(op);
        e.column     = 2'(col);
        e.round      = 4'(rnd);
        e.state_load = sl;
        e.mix_all    = mix;
        e.busy       = 1'b1;
        return e;
    endfunction

    // Expected per-cycle outputs of one run, straight from the round schedule.
    task automatic build_trace(input int sbc);
        obs_t e;
        exp_q.delete();
        e = '0;
        e.msg_load = 1'b1;
        e.busy     = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(mk(1, 0, NR, 1'b1, 1'b0));
        for (int r = NR - 1; r >= 1; r--) begin
            exp_q.push_back(mk(2, 0, r, 1'b1, 1'b0));
            for (int c = 0; c < sbc; c++) exp_q.push_back(mk(3, 0, r, c == sbc - 1, 1'b0));
            exp_q.push_back(mk(1, 0, r, 1'b1, 1'b0));
            if (IMC_CYCLES == 1) exp_q.push_back(mk(4, 0, r, 1'b1, 1'b1));
            else for (int c = 0; c < 4; c++) exp_q.push_back(mk(4, c, r, 1'b1, 1'b0));
        end
        exp_q.push_back(mk(2, 0, 0, 1'b1, 1'b0));
        for (int c = 0; c < sbc; c++) exp_q.push_back(mk(3, 0, 0, c == sbc - 1, 1'b0));
        exp_q.push_back(mk(1, 0, 0, 1'b1, 1'b0));
    endtask

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 0) begin
            o.msg_load = bus0.msg_load; o.op = bus0.op; o.column = bus0.column;
            o.round = bus0.round; o.state_load = bus0.state_load; o.mix_all = bus0.mix_all;
            o.busy = bus0.busy; o.done = bus0.done;
        end else begin
            o.msg_load = bus3.msg_load; o.op = bus3.op; o.column = bus3.column;
            o.round = bus3.round; o.state_load = bus3.state_load; o.mix_all = bus3.mix_all;
            o.busy = bus3.busy; o.done = bus3.done;
        end
        return o;
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) bus0.start = v;
        else bus3.start = v;
    endtask

    task automatic compare_obs(input string tag, input obs_t o, input obs_t e);
        check({tag, ".msg_load"}, 32'(o.msg_load), 32'(e.msg_load));
        check({tag, ".op"}, 32'(o.op), 32'(e.op));
        check({tag, ".column"}, 32'(o.column), 32'(e.column));
        check({tag, ".state_load"}, 32'(o.state_load), 32'(e.state_load));
        check({tag, ".mix_all"}, 32'(o.mix_all), 32'(e.mix_all));
        check({tag, ".busy"}, 32'(o.busy), 32'(e.busy));
        check({tag, ".done"}, 32'(o.done), 32'(e.done));
        if (e.op != 3'd0) check({tag, ".round"}, 32'(o.round), 32'(e.round));
    endtask

    task automatic check_idle(input string tag, input int sel);
        obs_t o;
        o = sample(sel);
        compare_obs(tag, o, '0);
        check({tag, ".round"}, 32'(o.round), 32'd0);
    endtask

    // One full run: start held for `hold` sampled edges, then per-cycle and aggregate checks.
    task automatic do_run(input int sel, input int sbc, input int hold, input string tag);
        obs_t o;
        int busy_n = 0, sl_n = 0, ml_n = 0, mix_n = 0, ark_top = 0, ark_zero = 0;
        build_trace(sbc);
        set_start(sel, 1'b1);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k + 1 == hold) set_start(sel, 1'b0);
            o = sample(sel);
            compare_obs($sformatf("%s.c%0d", tag, k), o, exp_q[k]);
            busy_n += int'(o.busy === 1'b1);
            sl_n   += int'(o.state_load === 1'b1);
            ml_n   += int'(o.msg_load === 1'b1);
            mix_n  += int'(o.mix_all === 1'b1 && o.op === 3'd4 && o.column === 2'd0);
            ark_top  += int'(o.op === 3'd1 && o.round === 4'(NR));
            ark_zero += int'(o.op === 3'd1 && o.round === 4'd0);
        end
        check({tag, ".busy_cycles"}, 32'(busy_n), 32'(2 + (NR - 1) * (IMC_CYCLES + 2 + sbc) + 2 + sbc));
        check({tag, ".state_loads"}, 32'(sl_n), 32'(1 + (NR - 1) * (3 + IMC_CYCLES) + 3));
        check({tag, ".msg_loads"}, 32'(ml_n), 32'd1);
        check({tag, ".mix_all_cycles"}, 32'(mix_n), (IMC_CYCLES == 1) ? 32'(NR - 1) : 32'd0);
        check({tag, ".ark_top"}, 32'(ark_top), 32'd1);
        check({tag, ".ark_zero"}, 32'(ark_zero), 32'd1);
        @(negedge clk);
        o = sample(sel);
        check({tag, ".done"}, 32'(o.done), 32'd1);
        check({tag, ".done_busy"}, 32'(o.busy), 32'd0);
        check({tag, ".done_op"}, 32'(o.op), 32'd0);
        if (hold > exp_q.size()) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                o = sample(sel);
                check($sformatf("%s.hold%0d.done", tag, k), 32'(o.done), 32'd1);
                check($sformatf("%s.hold%0d.busy", tag, k), 32'(o.busy), 32'd0);
                check($sformatf("%s.hold%0d.msg_load", tag, k), 32'(o.msg_load), 32'd0);
            end
            set_start(sel, 1'b0);
        end
        @(negedge clk);
        check_idle({tag, ".after"}, sel);
    endtask

    initial begin
        obs_t o;
        int   hold;
        reset = 1'b1;
        bus0.start = 1'b0;
        bus3.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset0", 0);
        check_idle("reset3", 1);
        reset = 1'b0;
        @(negedge clk);

        do_run(0, 1, 1, "pulse");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_run(0, 1, int'($urandom_range(2, 40)), "rand_hold");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_run(1, 3, int'($urandom_range(1, 20)), "sb3");

        // Abort at busy cycle 30 with Start high: reset must win.
        build_trace(1);
        hold = int'($urandom_range(1, 10));
        set_start(0, 1'b1);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k + 1 == hold) set_start(0, 1'b0);
            o = sample(0);
            compare_obs($sformatf("pre_abort.c%0d", k), o, exp_q[k]);
        end
        set_start(0, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        check_idle("abort", 0);
        reset = 1'b0;
        set_start(0, 1'b0);
        @(negedge clk);
        check_idle("abort_idle", 0);
        do_run(0, 1, 1, "rerun");

        do_run(0, 1, 1000, "held");
        @(negedge clk);
        check_idle("no_restart", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
